// File: rtl/mem2dp_link.sv
// mem2dp_link: bridges a memory request/response port onto a lane-serial debug-port link,
// with ack timeout, NAK retry and read parity checking.
module mem2dp_link #(
    parameter int N_DW        = 32,
    parameter int N_LANE      = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_RETRY   = 2
) (
    input  logic              dp_clk_i,
    input  logic              dp_rstn_i,
    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    input  logic              mem_req_type,
    input  logic [N_DW-1:0]   mem_req_addr,
    input  logic [N_DW-1:0]   mem_req_data,
    input  logic [N_DW/8-1:0] mem_req_mask,
    output logic              mem_resp_valid,
    input  logic              mem_resp_ready,
    output logic [N_DW-1:0]   mem_resp_data,
    output logic              mem_resp_err,
    output logic [N_LANE-1:0] dp_dat_o,
    output logic [N_LANE-1:0] dp_dat_oen,
    input  logic [N_LANE-1:0] dp_dat_i,
    output logic              dp_busy_o
);
    localparam int BEATS = N_DW / N_LANE;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = MAX_RETRY < 1 ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [7:0] RD_LAST  = 8'(2 * BEATS);
    localparam logic [7:0] WR_LAST  = 8'(3 * BEATS);
    localparam logic [7:0] RCV_LAST = 8'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, SEND, TURN, WAIT_START, ACK, RCV, PARITY, RESP} state_t;
    state_t state, nxt;

    logic              q_type;
    logic [N_DW/8-1:0] q_mask;
    logic [N_DW-1:0]   q_addr, q_data, rbuf;
    logic [3*N_DW-1:0] sh;
    logic [7:0]        cnt;
    logic [TW-1:0]     tmr;
    logic [RW-1:0]     retry;
    logic              err;
    logic [1:0]        ack_code;
    logic              accept, frame_done, rcv_done, timeout, ack_ok, ack_nak, retry_ok;
    logic [N_LANE-1:0] dat_d, oen_d;

    if (N_LANE == 1) begin : g_one
        assign ack_code = {1'b0, dp_dat_i[0]};
    end else begin : g_multi
        assign ack_code = dp_dat_i[1:0];
    end

    assign accept     = state == IDLE && mem_req_valid && dp_rstn_i;
    assign frame_done = cnt == (q_type ? WR_LAST : RD_LAST);
    assign rcv_done   = cnt == RCV_LAST;
    assign timeout    = state == WAIT_START && dp_dat_i[0] && tmr == TW'(1);
    assign ack_ok     = ack_code == 2'b01;
    assign ack_nak    = ack_code == 2'b10;
    assign retry_ok   = retry < RW'(MAX_RETRY);

    assign mem_req_ready  = accept;
    assign mem_resp_valid = state == RESP;
    assign mem_resp_err   = state == RESP && err;
    assign mem_resp_data  = (state == RESP && !err) ? rbuf : '1;
    assign dp_busy_o      = state != IDLE;

    always_ff @(posedge dp_clk_i or negedge dp_rstn_i) begin
        if (!dp_rstn_i) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:       nxt = accept ? SEND : IDLE;
            SEND:       nxt = frame_done ? TURN : SEND;
            TURN:       nxt = WAIT_START;
            WAIT_START: nxt = !dp_dat_i[0] ? ACK : timeout ? (retry_ok ? SEND : RESP) : WAIT_START;
            ACK:        nxt = ack_ok ? (q_type ? RESP : RCV) : (ack_nak && retry_ok) ? SEND : RESP;
            RCV:        nxt = rcv_done ? PARITY : RCV;
            PARITY:     nxt = RESP;
            RESP:       nxt = mem_resp_ready ? IDLE : RESP;
            default:    nxt = IDLE;
        endcase
    end

    // Lane drive is registered: the value computed here appears in the cycle nxt is entered.
    always_comb begin
        dat_d = '1;
        oen_d = '1;
        if (nxt == SEND) begin
            dat_d = state == SEND ? sh[N_LANE-1:0] : '0;
            oen_d = '0;
        end
    end

    always_ff @(posedge dp_clk_i or negedge dp_rstn_i) begin
        if (!dp_rstn_i) begin
            dp_dat_o   <= '1;
            dp_dat_oen <= '1;
            q_type     <= 1'b0;
            q_mask     <= '0;
            q_addr     <= '0;
            q_data     <= '0;
            rbuf       <= '0;
            sh         <= '0;
            cnt        <= '0;
            tmr        <= '0;
            retry      <= '0;
            err        <= 1'b0;
        end else begin
            dp_dat_o   <= dat_d;
            dp_dat_oen <= oen_d;
            if (accept) begin
                q_type <= mem_req_type;
                q_mask <= mem_req_mask;
                q_addr <= mem_req_addr;
                q_data <= mem_req_data;
                rbuf   <= '0;
                retry  <= '0;
                err    <= 1'b0;
            end
            if (nxt == SEND && state != SEND) begin
                sh  <= accept ? {mem_req_data, mem_req_addr, mem_req_type, {(N_DW-1-N_DW/8){1'b0}}, mem_req_mask}
                              : {q_data, q_addr, q_type, {(N_DW-1-N_DW/8){1'b0}}, q_mask};
                cnt <= '0;
                if (state != IDLE) retry <= retry + RW'(1);
            end else if (state == SEND) begin
                sh  <= sh >> N_LANE;
                cnt <= cnt + 8'd1;
            end else if (state == ACK) begin
                cnt <= '0;
            end else if (state == RCV) begin
                rbuf <= (rbuf >> N_LANE) | (N_DW'(dp_dat_i) << (N_DW - N_LANE));
                cnt  <= cnt + 8'd1;
            end
            if (state == TURN) tmr <= TW'(ACK_TIMEOUT);
            else if (state == WAIT_START) tmr <= tmr - TW'(1);
            if (timeout && !retry_ok) err <= 1'b1;
            if (state == ACK && !ack_ok && !(ack_nak && retry_ok)) err <= 1'b1;
            if (state == PARITY && dp_dat_i[0] != ^rbuf) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem2dp_link.sv
// tb_mem2dp_link: directed checks of framing, ack/retry handling, parity, reset and response stall.
module tb_mem2dp_link;
    logic        clk = 0;
    logic        rstn;
    logic        mem_req_valid, mem_req_ready, mem_req_type;
    logic [31:0] mem_req_addr, mem_req_data, mem_resp_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid, mem_resp_ready, mem_resp_err;
    logic [7:0]  dp_dat_o, dp_dat_oen, dp_dat_i;
    logic        dp_busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] beats[$];
    int waits[$];
    int nframes;
    logic [7:0] exp_wr[13] = '{8'h00, 8'h0F, 8'h00, 8'h00, 8'h80, 8'h40, 8'h00, 8'h00, 8'h10,
                               8'h01, 8'h00, 8'hA5, 8'hA5};

    mem2dp_link dut (
        .dp_clk_i(clk), .dp_rstn_i(rstn),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_type(mem_req_type),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
        .dp_dat_o(dp_dat_o), .dp_dat_oen(dp_dat_oen), .dp_dat_i(dp_dat_i), .dp_busy_o(dp_busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Code -1 means the target stays silent for that attempt; 1=OK, 2=NAK, 3=FAULT.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input int c0, input int c1, input int c2,
                       input int dly, input logic [31:0] rd, input logic par);
        int codes[3];
        int guard;
        int n;
        bit done = 0;
        codes[0] = c0;
        codes[1] = c1;
        codes[2] = c2;
        beats.delete();
        waits.delete();
        nframes = 0;
        mem_req_type = wr;
        mem_req_addr = addr;
        mem_req_data = data;
        mem_req_mask = mask;
        mem_req_valid = 1;
        #1;
        check("req_ready", mem_req_ready, 1);
        tick();
        mem_req_valid = 0;
        for (int a = 0; a < 3 && !done; a++) begin
            guard = 0;
            while (dp_dat_oen == 8'h00 && guard < 200) begin
                beats.push_back(dp_dat_o);
                tick();
                guard++;
            end
            check("send_bound", guard < 200, 1);
            nframes++;
            if (codes[a] < 0) begin
                n = 0;
                while (dp_dat_oen != 8'h00 && !mem_resp_valid && n < 100) begin
                    tick();
                    n++;
                end
                waits.push_back(n - 1);
                if (mem_resp_valid || n >= 100) done = 1;
            end else begin
                repeat (dly + 1) tick();
                dp_dat_i = 8'hFE;
                tick();
                dp_dat_i = 8'hFC | 8'(codes[a]);
                tick();
                if (codes[a] == 1 && !wr) begin
                    for (int b = 0; b < 4; b++) begin
                        dp_dat_i = rd[8*b +: 8];
                        tick();
                    end
                    dp_dat_i = {7'h7F, par};
                    tick();
                end
                dp_dat_i = 8'hFF;
                if (codes[a] != 2) done = 1;
            end
        end
        check("resp_valid", mem_resp_valid, 1);
        check("resp_oen", dp_dat_oen, 8'hFF);
    endtask

    task automatic finish_resp();
        mem_resp_ready = 1;
        tick();
        mem_resp_ready = 0;
        check("idle_busy", dp_busy_o, 0);
        check("idle_valid", mem_resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        rstn = 0;
        mem_req_valid = 0;
        mem_req_type = 0;
        mem_req_addr = 0;
        mem_req_data = 0;
        mem_req_mask = 0;
        mem_resp_ready = 0;
        dp_dat_i = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_oen", dp_dat_oen, 8'hFF);
        check("rst_dat", dp_dat_o, 8'hFF);
        check("rst_busy", dp_busy_o, 0);
        check("rst_rdata", mem_resp_data, 32'hFFFF_FFFF);
        rstn = 1;
        tick();

        txn(1, 32'h1000_0040, 32'hA5A5_0001, 4'hF, 1, -1, -1, 3, 32'h0, 1'b0);
        check("wr_frames", nframes, 1);
        check("wr_len", beats.size(), 13);
        for (int i = 0; i < 13 && i < beats.size(); i++) check($sformatf("wr_beat%0d", i), beats[i], exp_wr[i]);
        check("wr_err", mem_resp_err, 0);
        check("wr_data", mem_resp_data, 32'h0);
        finish_resp();

        // XOR-reduce of 0x12345678 is 1, so 1 is the matching parity bit.
        txn(0, 32'h2000_0010, 32'h0, 4'h3, 1, -1, -1, 2, 32'h1234_5678, 1'b1);
        check("rd_len", beats.size(), 9);
        check("rd_hdr", beats[1], 8'h03);
        check("rd_addr3", beats[8], 8'h20);
        check("rd_err", mem_resp_err, 0);
        check("rd_data", mem_resp_data, 32'h1234_5678);
        finish_resp();

        txn(0, 32'h2000_0010, 32'h0, 4'hF, 1, -1, -1, 0, 32'h1234_5678, 1'b0);
        check("par_err", mem_resp_err, 1);
        check("par_data", mem_resp_data, 32'hFFFF_FFFF);
        finish_resp();

        txn(0, 32'h0000_0100, 32'h0, 4'hF, -1, -1, -1, 0, 32'h0, 1'b0);
        check("to_frames", nframes, 3);
        check("to_beats", beats.size(), 27);
        for (int i = 0; i < waits.size(); i++) check($sformatf("to_wait%0d", i), waits[i], 16);
        check("to_err", mem_resp_err, 1);
        check("to_data", mem_resp_data, 32'hFFFF_FFFF);
        finish_resp();

        txn(1, 32'h0000_0200, 32'h0000_BEEF, 4'h1, 2, 1, -1, 1, 32'h0, 1'b0);
        check("nak_frames", nframes, 2);
        check("nak_beats", beats.size(), 26);
        check("nak_restart", beats[13], 8'h00);
        check("nak_err", mem_resp_err, 0);
        finish_resp();

        txn(0, 32'h0000_0300, 32'h0, 4'hF, 3, -1, -1, 0, 32'h0, 1'b0);
        check("fault_frames", nframes, 1);
        check("fault_err", mem_resp_err, 1);
        check("fault_data", mem_resp_data, 32'hFFFF_FFFF);
        finish_resp();

        // Abort mid-frame with a request still pending on the port.
        mem_req_type = 1;
        mem_req_addr = 32'h1000_0040;
        mem_req_data = 32'hA5A5_0001;
        mem_req_mask = 4'hF;
        mem_req_valid = 1;
        tick();
        repeat (5) tick();
        check("busy_ready", mem_req_ready, 0);
        check("pre_rst_beat5", dp_dat_o, 8'h40);
        check("pre_rst_oen", dp_dat_oen, 8'h00);
        rstn = 0;
        #1;
        check("arst_oen", dp_dat_oen, 8'hFF);
        check("arst_dat", dp_dat_o, 8'hFF);
        check("arst_busy", dp_busy_o, 0);
        check("arst_ready", mem_req_ready, 0);
        check("arst_valid", mem_resp_valid, 0);
        check("arst_err", mem_resp_err, 0);
        check("arst_rdata", mem_resp_data, 32'hFFFF_FFFF);
        mem_req_valid = 0;
        tick();
        rstn = 1;
        bad = 0;
        repeat (30) begin
            tick();
            if (mem_resp_valid || dp_busy_o) bad++;
        end
        check("abort_silent", bad, 0);

        txn(1, 32'h0000_0400, 32'h1111_2222, 4'hF, 1, -1, -1, 0, 32'h0, 1'b0);
        mem_req_valid = 1;
        mem_req_type = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("stall_valid%0d", i), mem_resp_valid, 1);
            check($sformatf("stall_data%0d", i), mem_resp_data, 32'h0);
            check($sformatf("stall_err%0d", i), mem_resp_err, 0);
            check($sformatf("stall_ready%0d", i), mem_req_ready, 0);
        end
        mem_resp_ready = 1;
        #1;
        check("resp_done_ready", mem_req_ready, 0);
        tick();
        mem_resp_ready = 0;
        check("post_resp_idle", dp_busy_o, 0);
        check("post_resp_ready", mem_req_ready, 1);
        mem_req_valid = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
